// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: reset vector, legal fetch
// window, the NOP/exception codes and the fetch-queue entry layout.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_HI_DEF    = 32'h0000_6FFC;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL     = 5'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fetch_entry_t;

    // True when a fetch address is misaligned or outside [lo, hi].
    function automatic logic pc_illegal(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/f_fetch_queue.sv
// In-order fetch queue between imem responses and the D stage.
// Synchronous active-low reset, flush has priority over push/pop, and a
// push is accepted while full only when a pop frees a slot the same cycle.
module f_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads under a credit limit, tracks
// the pc of every in-flight read, drops wrong-path responses after a
// redirect and presents the queue head to the D stage.
// Optional feature macro: F_ADDR_CHECK_EN (alignment/range check with a
// fetch exception entry and halt until the next redirect).
module f_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          FQ_DEPTH = 2
`ifdef F_ADDR_CHECK_EN
    ,
    parameter logic [31:0] PC_HI    = PC_HI_DEF
`endif
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        d_ready,
    output logic        out_exc
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
`ifdef F_ADDR_CHECK_EN
    localparam int ENTRY_W = $bits(fetch_entry_t);
`else
    localparam int ENTRY_W = 64;
`endif

    logic [31:0]        pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      discard;
    logic [CW-1:0]      fq_count;
    logic               q_full;
    logic               q_empty;
    logic               q_pop;
    logic               q_push;
    logic [ENTRY_W-1:0] q_push_data;
    logic [ENTRY_W-1:0] q_head;
    logic [31:0]        head_pc;
    logic [31:0]        head_instr;
    logic               head_exc;
    logic               credit_ok;
    logic               fetch_ok;
    logic               issue;
    logic               resp;
    logic               resp_keep;
    logic [31:0]        resp_pc;
    logic [31:0]        ifl_pc [FQ_DEPTH];
    logic [PW-1:0]      ifl_rd;
    logic [PW-1:0]      ifl_wr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every read holds a credit from issue until its entry leaves the queue,
    // so a returning response always finds a free queue slot.
    assign credit_ok = !q_full &&
                       (({1'b0, outstanding} + {1'b0, fq_count}) < (CW+1)'(FQ_DEPTH));
    assign imem_req  = reset && !redirect_en && credit_ok && fetch_ok;
    assign imem_addr = pc;
    assign issue     = imem_req && imem_ready;
    assign resp      = imem_rvalid && (outstanding != '0);
    assign resp_keep = resp && (discard == '0);
    assign resp_pc   = ifl_pc[ifl_rd];
    assign q_pop     = d_ready && !q_empty;

`ifdef F_ADDR_CHECK_EN
    logic         pc_bad;
    logic         halted;
    logic         exc_push;
    fetch_entry_t head_e;

    assign pc_bad   = pc_illegal(pc, RESET_PC, PC_HI);
    assign fetch_ok = !pc_bad && !halted;
    assign exc_push = pc_bad && !halted && (outstanding == '0) && !redirect_en &&
                      (!q_full || q_pop);
    assign q_push   = resp_keep || exc_push;
    assign q_push_data = exc_push ? {pc, NOP_INSTR, 1'b1} : {resp_pc, imem_rdata, 1'b0};
    assign head_e     = q_head;
    assign head_pc    = head_e.pc;
    assign head_instr = head_e.instr;
    assign head_exc   = head_e.exc;

    // Halt after reporting a bad fetch address until software redirects.
    always_ff @(posedge clk) begin
        if (!reset) begin
            halted <= 1'b0;
        end else if (redirect_en) begin
            halted <= 1'b0;
        end else if (exc_push) begin
            halted <= 1'b1;
        end
    end
`else
    assign fetch_ok    = 1'b1;
    assign q_push      = resp_keep;
    assign q_push_data = {resp_pc, imem_rdata};
    assign head_pc     = q_head[63:32];
    assign head_instr  = q_head[31:0];
    assign head_exc    = 1'b0;
`endif

    assign out_valid = !q_empty;
    assign out_pc    = q_empty ? pc : head_pc;
    assign out_instr = q_empty ? NOP_INSTR : head_instr;
    assign out_exc   = !q_empty && head_exc;

    // PC, in-flight/discard counters and in-flight FIFO pointers; a redirect
    // marks everything still in flight after this cycle's response as stale.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            ifl_rd      <= '0;
            ifl_wr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            if (redirect_en) begin
                pc      <= redirect_pc;
                discard <= outstanding - CW'(resp);
            end else begin
                if (issue) begin
                    pc <= pc + 32'd4;
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
            if (issue) begin
                ifl_wr <= ptr_inc(ifl_wr);
            end
            if (resp) begin
                ifl_rd <= ptr_inc(ifl_rd);
            end
        end
    end

    // Remember the address of each accepted read so its response can be tagged.
    always_ff @(posedge clk) begin
        if (issue) begin
            ifl_pc[ifl_wr] <= pc;
        end
    end

    f_fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_en),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (fq_count)
    );

endmodule
